prm_edge_mask_engine: RTL
=========================

// Module: prm_edge_mask_engine
// PURPOSE
// - Programmable, sequential successor to the fixed per-edge obstacle-check truth tables.
// - Each of N_EDGES roadmap edges holds up to N_CUBES sum-of-products cubes over an N_IN-bit occupancy word.
// - The engine accepts one occupancy query and scans one cube index per cycle, with all edges evaluated in parallel.
// - It returns edge_mask[N_EDGES-1:0]; bit e = 1 means edge e is blocked.
// - Sits between the occupancy sampler and the PRM planner; cube tables are reloaded at runtime instead of resynthesised.
// PARAMETERS
// - N_IN     15  occupancy bits per query (A..O order: bit0=A)
// - N_EDGES  8   edge lanes evaluated in parallel
// - N_CUBES  16  cube slots per edge (scan length)
// PORTS
// - clk        in   1                   clock, rising edge
// - rst        in   1                   synchronous, active-high reset
// - in_valid   in   1                   occupancy query valid
// - in_ready   out  1                   engine idle, can accept query
// - in_occ     in   N_IN                occupancy word
// - out_valid  out  1                   edge_mask valid
// - out_ready  in   1                   consumer accepts result
// - edge_mask  out  N_EDGES             per-edge blocked flags
// - cfg_we     in   1                   cube table write strobe
// - cfg_edge   in   $clog2(N_EDGES)     target edge
// - cfg_cube   in   $clog2(N_CUBES)     target cube slot
// - cfg_care   in   N_IN                1 = literal present in cube
// - cfg_value  in   N_IN                required polarity where care=1
// - cfg_cube_en in  1                   slot enable (0 = empty cube)
// - cfg_err    out  1                   one-cycle pulse: write rejected
// - busy       out  1                   state != IDLE
// BEHAVIOUR
// - Reset: state=IDLE, in_ready=1, out_valid=0, edge_mask=0, cfg_err=0, busy=0, all cube_en=0, idx=0.
// - Reset clears table contents; an unconfigured query therefore yields mask 0.
// - Cube match: cube_en & (((occ ^ value) & care) == 0). A cube with care=0 and en=1 always matches.
// - Cube table writes are accepted only in IDLE.
// - A write arriving in SCAN or DONE is dropped, and cfg_err pulses on the next cycle.
// - FSM:
//   - IDLE: in_ready=1. On in_valid: latch occ, clear acc, idx=0, go to SCAN.
//   - SCAN: for every edge e, acc[e] |= match(e, idx).
//     - If idx == N_CUBES-1, go to DONE; otherwise idx++.
//   - DONE: out_valid=1 and edge_mask=acc, held stable until out_ready; then go to IDLE.
//   - On the out_ready cycle out_valid drops and in_ready rises on the next cycle. There is no bypass.
// - Latency: query accepted at edge t gives out_valid high after edge t+N_CUBES. Throughput is 1 query per N_CUBES+2 cycles.
// - In_ready, busy and out_valid are registered-state decodes, with no combinational path from in_valid or out_ready.
// - Write and query accepted in the same IDLE cycle: the write commits on that edge, and the query scan sees the new contents.
// - Rst mid-SCAN or mid-DONE: the result is discarded, and no out_valid is produced.
// - idx width is $clog2(N_CUBES). There is no wrap, because exit happens at N_CUBES-1.
// CONFIGURATION
// - Macro PRM_EARLY_EXIT_EN.
// - When defined, SCAN also exits to DONE once (acc | this-cycle matches) is all ones, or once all remaining slots idx+1..N_CUBES-1 are disabled for every edge.
// - With the macro defined, latency is 1..N_CUBES cycles of SCAN, and edge_mask is identical to the full scan.
// - When not defined, the scan length is always N_CUBES; the logic and the result are unchanged.
// STRUCTURE
// - Package prm_chk_pkg holds:
//   - state_e {IDLE, SCAN, DONE};
//   - cube_t struct {logic en; logic [N_IN-1:0] care, value};
//   - default N_IN/N_EDGES/N_CUBES localparams.
// - Sub-module prm_cube_match is the single-cube comparator: (cube_t, occ) -> match. It is instantiated N_EDGES times.
// - The cube table is a register array cube_t tbl[N_EDGES][N_CUBES], read by idx.
// TESTING
// 1. Reset, then query occ=15'h7FFF -> mask=8'h00 after N_CUBES+1 cycles; cfg_err never pulses.
// 2. Write edge3 cube5 {en=1, care=15'h0003, value=15'h0001}.
//    - occ=15'h0001 -> mask=8'h08.
//    - occ=15'h0003 -> mask=8'h00.
// 3. Hold out_ready=0 for 10 cycles in DONE: mask stays stable, in_ready=0, and a second in_valid is not accepted.
// 4. Assert cfg_we during SCAN -> cfg_err pulses 1 cycle, and a re-query shows the table unchanged.
// 5. Assert rst mid-SCAN (idx=7) -> next cycle IDLE, out_valid=0, mask=0, table cleared.
// 6. With PRM_EARLY_EXIT_EN: all 8 edges have an always-match cube at slot 0 -> out_valid after 2 cycles, mask=8'hFF.
//    - Without the macro the same stimulus takes N_CUBES+1 cycles.

Source files
------------

// File: rtl/prm_chk_pkg.sv
// Shared types and default sizes for the PRM edge mask engine.
// Latency: none (types and constants only).
// Backpressure: none (types and constants only).
package prm_chk_pkg;

    localparam int DEF_N_IN    = 15;
    localparam int DEF_N_EDGES = 8;
    localparam int DEF_N_CUBES = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } state_e;

    // One sum-of-products term. A literal takes part only where care is set.
    typedef struct packed {
        logic                en;
        logic [DEF_N_IN-1:0] care;
        logic [DEF_N_IN-1:0] value;
    } cube_t;

endpackage

// File: rtl/prm_cube_match.sv
// Single-cube comparator: is the occupancy word covered by this cube?
// Latency: combinational, zero cycles.
// Backpressure: none, pure function of its inputs.
module prm_cube_match
    import prm_chk_pkg::*;
(
    input  cube_t               cube,
    input  logic [DEF_N_IN-1:0] occ,
    output logic                match
);

    // Every cared-for bit must equal its required polarity. An empty cube never matches.
    assign match = cube.en & (((occ ^ cube.value) & cube.care) == '0);

endmodule

// File: rtl/prm_edge_mask_engine.sv
// Programmable per-edge obstacle check: scans one cube slot per cycle for all edges at once.
// Latency: N_CUBES cycles of scan, fewer when PRM_EARLY_EXIT_EN is defined; result held in DONE.
// Backpressure: in_ready low outside IDLE; edge_mask held until out_ready; table writes outside IDLE dropped with cfg_err.
module prm_edge_mask_engine
    import prm_chk_pkg::*;
#(
    parameter  int N_EDGES = DEF_N_EDGES,
    parameter  int N_CUBES = DEF_N_CUBES,
    localparam int N_IN    = DEF_N_IN,
    localparam int EW      = $clog2(N_EDGES),
    localparam int IW      = $clog2(N_CUBES)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [N_IN-1:0]    in_occ,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [N_EDGES-1:0] edge_mask,
    input  logic               cfg_we,
    input  logic [EW-1:0]      cfg_edge,
    input  logic [IW-1:0]      cfg_cube,
    input  logic [N_IN-1:0]    cfg_care,
    input  logic [N_IN-1:0]    cfg_value,
    input  logic               cfg_cube_en,
    output logic               cfg_err,
    output logic               busy
);

    state_e             state;
    logic [IW-1:0]      idx;
    logic [N_IN-1:0]    occ_q;
    logic [N_EDGES-1:0] acc;
    logic [N_EDGES-1:0] hit;
    logic [N_EDGES-1:0] acc_next;
    logic               scan_last;
    logic               scan_exit;

    cube_t tbl [N_EDGES][N_CUBES];

    // One comparator per edge lane, all looking at the slot selected by idx.
    for (genvar e = 0; e < N_EDGES; e++) begin : g_lane
        prm_cube_match u_match (
            .cube  (tbl[e][idx]),
            .occ   (occ_q),
            .match (hit[e])
        );
    end

    assign acc_next  = acc | hit;
    assign scan_last = (idx == IW'(N_CUBES - 1));

`ifdef PRM_EARLY_EXIT_EN
    logic [N_CUBES-1:0] slot_en;
    logic [N_CUBES-1:0] rest_en;

    // Per slot: is any edge's cube enabled in that slot.
    always_comb begin
        slot_en = '0;
        for (int j = 0; j < N_CUBES; j++) begin
            for (int e = 0; e < N_EDGES; e++) begin
                slot_en[j] = slot_en[j] | tbl[e][j].en;
            end
        end
    end

    // Slots strictly after idx; if none is enabled the accumulator is already final.
    assign rest_en   = (slot_en >> idx) >> 1;
    assign scan_exit = scan_last | (&acc_next) | ~(|rest_en);
`else
    assign scan_exit = scan_last;
`endif

    // Cube table: writes land only while idle, so a scan always sees a stable table.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int e = 0; e < N_EDGES; e++) begin
                for (int j = 0; j < N_CUBES; j++) begin
                    tbl[e][j] <= '0;
                end
            end
        end else if (cfg_we && (state == IDLE)) begin
            tbl[cfg_edge][cfg_cube] <= '{en: cfg_cube_en, care: cfg_care, value: cfg_value};
        end
    end

    // Control FSM with registered handshake, status and result outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            idx       <= '0;
            occ_q     <= '0;
            acc       <= '0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            edge_mask <= '0;
            cfg_err   <= 1'b0;
        end else begin
            cfg_err <= cfg_we && (state != IDLE);
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        occ_q    <= in_occ;
                        acc      <= '0;
                        idx      <= '0;
                        state    <= SCAN;
                        in_ready <= 1'b0;
                        busy     <= 1'b1;
                    end
                end
                SCAN: begin
                    acc <= acc_next;
                    if (scan_exit) begin
                        state     <= DONE;
                        out_valid <= 1'b1;
                        edge_mask <= acc_next;
                    end else begin
                        idx <= idx + IW'(1);
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state     <= IDLE;
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        busy      <= 1'b0;
                    end
                end
                default: begin
                    state     <= IDLE;
                    out_valid <= 1'b0;
                    in_ready  <= 1'b1;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

endmodule
